// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM encoding,
// default NOP word and the index-width helper.
package cpu_pkg;

  localparam logic [0:0]  ST_RUN       = 1'b0;
  localparam logic [0:0]  ST_LOAD      = 1'b1;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Single-write/single-read synchronous RAM, zero at power-up, no reset.
// The read register only updates on a read enable, so a stalled result stays put.
module inst_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rdata_q = '0;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_fetch.sv
// Synchronous-read instruction memory with fetch handshake, stall hold,
// address-error flagging and a run-time program-load mode.
//
// state | meaning
// RUN   | fetches accepted when downstream can take the result
// LOAD  | program-load writes allowed, fetch path blocked
module inst_mem_fetch
  import cpu_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 32,
  parameter int              DEPTH    = 64,
  parameter int              CNT_W    = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF),
  localparam int             IDX_W    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              stall,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic              inst_err,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [IDX_W-1:0]  load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_busy,
  output logic [CNT_W-1:0]  fetch_cnt
);

  logic [0:0]       state_q, state_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             ok_q, ok_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             addr_err;
  logic             load_enter;
  logic             mem_we;
  logic [DATA_W-1:0] rdata;

  assign fetch_ready = (state_q == ST_RUN) && !load_en && (!valid_q || !stall);
  assign accept      = fetch_req && fetch_ready;
  assign addr_err    = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (IDX_W + 2)) != '0);
  // Write is gated by rst so a write landing on the reset edge is dropped.
  assign mem_we      = !rst && (state_q == ST_LOAD) && load_we;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (load_en && !(valid_q && stall)) state_d = ST_LOAD;
      ST_LOAD: if (!load_en) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign load_enter = (state_q == ST_RUN) && (state_d == ST_LOAD);

  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    ok_d    = ok_q;
    cnt_d   = cnt_q;
    if (load_enter) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      err_d   = addr_err;
      ok_d    = !addr_err;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (!stall) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ok_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
      cnt_q   <= cnt_d;
    end
  end

  inst_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (accept),
    .raddr_i (fetch_addr[IDX_W+1:2]),
    .rdata_o (rdata)
  );

  // ok_q is clear after reset and after an erroneous fetch, which selects NOP.
  assign inst       = ok_q ? rdata : NOP_WORD;
  assign inst_valid = valid_q;
  assign inst_err   = err_q;
  assign load_busy  = (state_q == ST_LOAD);
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed bench for inst_mem_fetch (DEPTH=64, CNT_W=4 so the counter wrap is reachable).
module tb_inst_mem_fetch;

  logic        clk = 1'b0;
  logic        rst, fetch_req, fetch_ready, stall, inst_valid, inst_err;
  logic        load_en, load_we, load_busy;
  logic [31:0] fetch_addr, inst, load_data;
  logic [5:0]  load_addr;
  logic [3:0]  fetch_cnt;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  localparam logic [31:0] W1 = 32'h1400_0421;
  localparam logic [31:0] W2 = 32'h3800_0441;

  always #5 clk = ~clk;

  inst_mem_fetch #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .stall(stall), .inst_valid(inst_valid), .inst(inst),
    .inst_err(inst_err), .load_en(load_en), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .load_busy(load_busy), .fetch_cnt(fetch_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;
    load_en = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    step();
    rst = 1'b0;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else pass_cnt++;
    total_cnt++; if (inst !== 32'h0) $display("FAIL reset_inst: got %h want 00000000", inst); else pass_cnt++;
    total_cnt++; if (inst_err !== 1'b0) $display("FAIL reset_err: got %b want 0", inst_err); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); else pass_cnt++;
    total_cnt++; if (load_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", load_busy); else pass_cnt++;
    total_cnt++; if (fetch_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", fetch_ready); else pass_cnt++;
  endtask

  task automatic test_load_fetch();
    load_en = 1'b1;
    step();
    total_cnt++; if (load_busy !== 1'b1) $display("FAIL load_busy: got %b want 1", load_busy); else pass_cnt++;
    load_we = 1'b1; load_addr = 6'd1; load_data = W1;
    step();
    load_addr = 6'd2; load_data = W2;
    step();
    load_we = 1'b0; load_en = 1'b0;
    step();
    total_cnt++; if (load_busy !== 1'b0) $display("FAIL load_exit_busy: got %b want 0", load_busy); else pass_cnt++;
    fetch_req = 1'b1; fetch_addr = 32'h4;
    step();
    total_cnt++; if (inst_valid !== 1'b1 || inst !== W1) $display("FAIL b2b_first: got v=%b %h want v=1 %h", inst_valid, inst, W1); else pass_cnt++;
    fetch_addr = 32'h8;
    step();
    total_cnt++; if (inst_valid !== 1'b1 || inst !== W2) $display("FAIL b2b_second: got v=%b %h want v=1 %h", inst_valid, inst, W2); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 4'd2) $display("FAIL b2b_cnt: got %0d want 2", fetch_cnt); else pass_cnt++;
    fetch_req = 1'b0;
    step();
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL drain_valid: got %b want 0", inst_valid); else pass_cnt++;
  endtask

  task automatic test_stall_hold();
    fetch_req = 1'b1; fetch_addr = 32'h4;
    step();
    fetch_addr = 32'h8; stall = 1'b1;
    #1;
    total_cnt++; if (fetch_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", fetch_ready); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (inst_valid !== 1'b1 || inst !== W1 || fetch_ready !== 1'b0 || fetch_cnt !== 4'd3)
        $display("FAIL stall_hold%0d: got v=%b %h rdy=%b cnt=%0d want v=1 %h rdy=0 cnt=3",
                 i, inst_valid, inst, fetch_ready, fetch_cnt, W1);
      else pass_cnt++;
    end
    stall = 1'b0;
    #1;
    total_cnt++; if (fetch_ready !== 1'b1) $display("FAIL unstall_ready: got %b want 1", fetch_ready); else pass_cnt++;
    step();
    total_cnt++; if (inst !== W2 || fetch_cnt !== 4'd4) $display("FAIL unstall_inst: got %h cnt=%0d want %h cnt=4", inst, fetch_cnt, W2); else pass_cnt++;
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_addr_err();
    fetch_req = 1'b1; fetch_addr = 32'h6;
    step();
    total_cnt++; if (inst_err !== 1'b1 || inst !== 32'h0 || inst_valid !== 1'b1) $display("FAIL err_misalign: got e=%b %h v=%b want e=1 00000000 v=1", inst_err, inst, inst_valid); else pass_cnt++;
    fetch_addr = 32'h100;
    step();
    total_cnt++; if (inst_err !== 1'b1 || inst !== 32'h0) $display("FAIL err_range: got e=%b %h want e=1 00000000", inst_err, inst); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 4'd6) $display("FAIL err_cnt: got %0d want 6", fetch_cnt); else pass_cnt++;
    fetch_addr = 32'h4;
    step();
    total_cnt++; if (inst_err !== 1'b0 || inst !== W1) $display("FAIL err_recover: got e=%b %h want e=0 %h", inst_err, inst, W1); else pass_cnt++;
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_collision();
    fetch_req = 1'b1; fetch_addr = 32'h4;
    step();
    load_en = 1'b1; fetch_addr = 32'h8;
    #1;
    total_cnt++; if (fetch_ready !== 1'b0) $display("FAIL coll_ready: got %b want 0", fetch_ready); else pass_cnt++;
    step();
    total_cnt++; if (load_busy !== 1'b1 || inst_valid !== 1'b0) $display("FAIL coll_enter: got busy=%b v=%b want busy=1 v=0", load_busy, inst_valid); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 4'd8) $display("FAIL coll_cnt: got %0d want 8", fetch_cnt); else pass_cnt++;
    step();
    total_cnt++; if (fetch_ready !== 1'b0 || load_busy !== 1'b1) $display("FAIL coll_hold: got rdy=%b busy=%b want rdy=0 busy=1", fetch_ready, load_busy); else pass_cnt++;
    fetch_req = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    load_we = 1'b1; load_addr = 6'd3; load_data = 32'hDEAD_BEEF; rst = 1'b1;
    step();
    total_cnt++; if (load_busy !== 1'b0 || fetch_cnt !== 4'd0) $display("FAIL rstload_state: got busy=%b cnt=%0d want busy=0 cnt=0", load_busy, fetch_cnt); else pass_cnt++;
    rst = 1'b0; load_we = 1'b0; load_en = 1'b0;
    step();
    fetch_req = 1'b1; fetch_addr = 32'hC;
    step();
    total_cnt++; if (inst !== 32'h0 || inst_err !== 1'b0) $display("FAIL rstload_nowrite: got %h e=%b want 00000000 e=0", inst, inst_err); else pass_cnt++;
    fetch_addr = 32'h4;
    step();
    total_cnt++; if (inst !== W1) $display("FAIL rstload_keep: got %h want %h", inst, W1); else pass_cnt++;
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_cnt_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h8;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 16) begin
        total_cnt++; if (fetch_cnt !== 4'd0) $display("FAIL wrap_16: got %0d want 0", fetch_cnt); else pass_cnt++;
      end
    end
    fetch_req = 1'b0;
    total_cnt++; if (fetch_cnt !== 4'd1 || inst !== W2) $display("FAIL wrap_17: got cnt=%0d %h want cnt=1 %h", fetch_cnt, inst, W2); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_stall_hold();
    test_addr_err();
    test_collision();
    test_reset_mid_load();
    test_cnt_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
